bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbitrates the shared memory-mapped peripheral bus (address_bus, data_bus, read, write) between NUM_MASTERS requesters, e.g. the CPU datapath and a future DMA/text-blit engine.
- Sequences each transfer as address setup, then strobe, then completion, so the vga_text, keyboard and seven-segment peripherals see clean, non-overlapping cycles.
- Uses round-robin fairness, with an optional bounded bus lock for read-modify-write.

Parameters:
- NUM_MASTERS, 2: number of requesters; must be 2 or more.
- STROBE_CYCLES, 1: cycles read or write is held asserted per transfer; must be 1 or more.
- MAX_LOCK, 4: maximum back-to-back transfers one master may chain with m_lock before it is forced to release the bus.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master transfer request.
- m_write  in  NUM_MASTERS  per master: 1 = write, 0 = read.
- m_lock  in  NUM_MASTERS  per master: request to keep the grant after this transfer.
- m_address  in  NUM_MASTERS*64  packed addresses; master i occupies bits [64i+63:64i].
- m_wdata  in  NUM_MASTERS*64  packed write data, same packing.
- m_grant  out  NUM_MASTERS  one-hot (or zero) owner of the bus.
- m_done  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_rdata  out  64  read data; valid while m_done is high.
- address_bus  out  64  shared bus address.
- data_bus  inout  64  shared bidirectional data bus.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, m_grant=0, m_done=0, m_rdata=0, address_bus=0, read=0, write=0, busy=0.
  - data_bus is released to high-Z.
  - last_grant=NUM_MASTERS-1, so master 0 wins first; lock_cnt=0.
  - Reset mid-transfer aborts the transfer immediately: strobes drop asynchronously and no m_done is issued.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - m_req is sampled only in IDLE.
  - If any bit is set, the winner is the first requester found scanning from last_grant+1 upward, wrapping modulo NUM_MASTERS.
  - Latch the winner's index, address, write flag and wdata; set m_grant[winner]; go to SETUP.
- SETUP (1 cycle): address_bus = latched address; read=0, write=0. Go to STROBE.
- STROBE (STROBE_CYCLES cycles, down-counted):
  - Assert read or write according to the latched flag.
  - Write: data_bus driven with the latched wdata.
  - Read: data_bus is high-Z.
  - On the final STROBE cycle's edge, a read captures data_bus into m_rdata. Go to HOLD.
- HOLD (1 cycle):
  - read=0 and write=0; m_done[owner]=1; data_bus high-Z; address_bus holds its value.
  - Lock chain: if m_lock[owner], m_req[owner] and lock_cnt < MAX_LOCK-1, then lock_cnt++, latch the owner's new operation, keep m_grant and go to SETUP.
  - Otherwise: lock_cnt=0, last_grant=owner, m_grant=0, go to IDLE.
- Latency:
  - Edge 0: request sampled in IDLE.
  - Edge 1: read/write asserted.
  - Edge 1+STROBE_CYCLES: m_done asserted.
  - A non-locked master gets one transfer per 3+STROBE_CYCLES cycles.
- Requester behaviour and edge cases:
  - A master dropping m_req after grant does not cancel its transfer.
  - A master's inputs are ignored except when it is latched in IDLE or at a HOLD lock chain.
  - Simultaneous requests in IDLE are resolved by round-robin only; no static priority beyond the reset pointer.
  - A new request from the master that just finished waits behind all other pending requesters.
- Bus ownership: data_bus is never driven outside a write STROBE, and read and write are never high together.

Decomposition:
- Package bus_pkg holds:
  - the state encoding (IDLE, SETUP, STROBE, HOLD);
  - the data and address width constants (64);
  - the peripheral base-address constants shared with the bus peripherals.
- Sub-module rr_picker (combinational): inputs are the request vector and last_grant; outputs are a one-hot winner and a valid flag. It is reused by future interrupt or DMA-channel schedulers.

Test Plan:
1. Reset to single read: release reset; m_req=01, m_write=0, m_address[0]=0x1000, peripheral drives 0xABCD → read high exactly one cycle with address 0x1000; m_done=01 at edge 2 with m_rdata=0xABCD; data_bus never driven by the arbiter.
2. Contention: m_req=11 held continuously with plain writes → grants alternate 01,10,01,10; each write drives the correct m_wdata only during STROBE; a new grant every 4 cycles.
3. Lock with MAX_LOCK=4: master 1 has m_lock=1 and m_req=1 throughout while master 0 also requests → master 1 completes exactly 4 transfers back to back, then master 0 is granted.
4. STROBE_CYCLES=3, write 0x55 to 0x2000 → write high for 3 consecutive cycles; address stable from SETUP through HOLD; done 4 edges after request sample.
5. Reset mid-operation: assert reset during STROBE → read/write, m_grant and busy go 0 without a clock edge; no m_done; after release, master 0 wins first.
6. Request withdrawal: master 0 drops m_req the cycle after grant → its transfer still completes with m_done=01, then the bus goes IDLE.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus: transfer phases, bus widths and
// the base addresses the bus peripherals decode.
package bus_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_t;

    // Each peripheral owns a 64 KiB window starting at its base.
    localparam logic [ADDR_W-1:0] VGA_TEXT_BASE  = 64'h0000_0000_0001_0000;
    localparam logic [ADDR_W-1:0] KEYBOARD_BASE  = 64'h0000_0000_0002_0000;
    localparam logic [ADDR_W-1:0] SEVEN_SEG_BASE = 64'h0000_0000_0003_0000;
    localparam logic [ADDR_W-1:0] PERIPH_SPAN    = 64'h0000_0000_0001_0000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping modulo N. Returns a one-hot winner and a valid flag.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         winner,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            // last+i never exceeds 2N-1, so one conditional subtract wraps it
            idx = {1'b0, last} + (IW+1)'(i);
            if (idx >= (IW+1)'(N))
                idx = idx - (IW+1)'(N);
            if (!valid && req[idx[IW-1:0]]) begin
                winner[idx[IW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared peripheral bus. Each transfer runs
// SETUP -> STROBE (STROBE_CYCLES) -> HOLD, with an optional bounded lock chain.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int STROBE_CYCLES = 1,
    parameter int MAX_LOCK      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_grant,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             address_bus,
    inout  tri   [DATA_W-1:0]             data_bus,
    output logic                          read,
    output logic                          write,
    output logic                          busy
);

    localparam int IW  = $clog2(NUM_MASTERS);
    localparam int SCW = $clog2(STROBE_CYCLES) + 1;
    localparam int LCW = $clog2(MAX_LOCK) + 1;

    bus_state_t                           state;
    logic [IW-1:0]                        owner;
    logic [IW-1:0]                        last_grant;
    logic                                 op_write;
    logic [DATA_W-1:0]                    op_wdata;
    logic [SCW-1:0]                       strobe_cnt;
    logic [LCW-1:0]                       lock_cnt;

    logic [NUM_MASTERS-1:0][ADDR_W-1:0]   addr_arr;
    logic [NUM_MASTERS-1:0][DATA_W-1:0]   wdata_arr;
    logic [NUM_MASTERS-1:0]               pick_onehot;
    logic                                 pick_valid;
    logic [IW-1:0]                        win_idx;
    logic [IW-1:0]                        sel_idx;
    logic                                 chain_ok;

    assign addr_arr  = m_address;
    assign wdata_arr = m_wdata;

    rr_picker #(.N(NUM_MASTERS)) u_pick (
        .req    (m_req),
        .last   (last_grant),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (pick_onehot[i])
                win_idx = IW'(i);
    end

    // New operations are latched either from the IDLE winner or from the
    // current owner when it chains a locked transfer out of HOLD.
    assign sel_idx  = (state == IDLE) ? win_idx : owner;
    assign chain_ok = m_lock[owner] && m_req[owner] &&
                      (lock_cnt < LCW'(MAX_LOCK - 1));

    // The write strobe register doubles as the data_bus output enable.
    assign data_bus = write ? op_wdata : {DATA_W{1'bz}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            m_grant     <= '0;
            m_done      <= '0;
            m_rdata     <= '0;
            address_bus <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            busy        <= 1'b0;
            owner       <= '0;
            op_write    <= 1'b0;
            op_wdata    <= '0;
            strobe_cnt  <= '0;
            lock_cnt    <= '0;
            last_grant  <= IW'(NUM_MASTERS - 1);
        end else begin
            m_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= win_idx;
                        m_grant     <= pick_onehot;
                        busy        <= 1'b1;
                        address_bus <= addr_arr[sel_idx];
                        op_write    <= m_write[sel_idx];
                        op_wdata    <= wdata_arr[sel_idx];
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    strobe_cnt <= SCW'(STROBE_CYCLES - 1);
                    read       <= !op_write;
                    write      <= op_write;
                    state      <= STROBE;
                end
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        read   <= 1'b0;
                        write  <= 1'b0;
                        if (!op_write)
                            m_rdata <= data_bus;
                        m_done <= NUM_MASTERS'(1) << owner;
                        state  <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - SCW'(1);
                    end
                end
                HOLD: begin
                    if (chain_ok) begin
                        lock_cnt    <= lock_cnt + LCW'(1);
                        address_bus <= addr_arr[sel_idx];
                        op_write    <= m_write[sel_idx];
                        op_wdata    <= wdata_arr[sel_idx];
                        state       <= SETUP;
                    end else begin
                        lock_cnt   <= '0;
                        last_grant <= owner;
                        m_grant    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus-protocol invariants
    assert property (@(posedge clock) disable iff (!reset) !(read && write));
    assert property (@(posedge clock) disable iff (!reset) $onehot0(m_grant));
    assert property (@(posedge clock) disable iff (!reset) $onehot0(m_done));
    assert property (@(posedge clock) disable iff (!reset) (m_done == '0) || (m_done == m_grant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed table on a 2-master instance, hand sequences
// for slow strobe / async reset / withdrawal, and a random run against a model.
module tb_bus_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: 2 masters, single-cycle strobe, lock chain up to 4
    localparam logic [63:0] A0_ADDR = 64'h1000;
    localparam logic [63:0] A1_ADDR = 64'h3000;
    localparam logic [63:0] A0_WD   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] A1_WD   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] A_PERIPH = 64'hABCD;

    logic [1:0]   req_a, wr_a, lock_a, grant_a, done_a;
    logic [127:0] addr_a, wdata_a;
    logic [63:0]  rdata_a, abus_a, periph_a;
    logic         read_a, write_a, busy_a;
    wire  [63:0]  dbus_a;
    assign dbus_a = write_a ? {64{1'bz}} : periph_a;

    bus_arbiter #(.NUM_MASTERS(2), .STROBE_CYCLES(1), .MAX_LOCK(4)) dut_a (
        .clock(clock), .reset(reset), .m_req(req_a), .m_write(wr_a), .m_lock(lock_a),
        .m_address(addr_a), .m_wdata(wdata_a), .m_grant(grant_a), .m_done(done_a),
        .m_rdata(rdata_a), .address_bus(abus_a), .data_bus(dbus_a),
        .read(read_a), .write(write_a), .busy(busy_a)
    );

    // Instance B: 3 masters, 3-cycle strobe, lock chain up to 2
    localparam int SC_B = 3;
    localparam int ML_B = 2;

    logic [2:0]   req_b, wr_b, lock_b, grant_b, done_b;
    logic [191:0] addr_b, wdata_b;
    logic [63:0]  rdata_b, abus_b, periph_b;
    logic         read_b, write_b, busy_b;
    wire  [63:0]  dbus_b;
    assign dbus_b = write_b ? {64{1'bz}} : periph_b;

    bus_arbiter #(.NUM_MASTERS(3), .STROBE_CYCLES(SC_B), .MAX_LOCK(ML_B)) dut_b (
        .clock(clock), .reset(reset), .m_req(req_b), .m_write(wr_b), .m_lock(lock_b),
        .m_address(addr_b), .m_wdata(wdata_b), .m_grant(grant_b), .m_done(done_b),
        .m_rdata(rdata_b), .address_bus(abus_b), .data_bus(dbus_b),
        .read(read_b), .write(write_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] req, wr, lock, grant, done;
        logic       rd, wt, busy, chk_rd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] rq, logic [1:0] wr, logic [1:0] lk,
                                logic [1:0] g, logic [1:0] d,
                                logic r, logic w, logic b, logic c);
        vec_t v;
        v.req = rq; v.wr = wr; v.lock = lk; v.grant = g; v.done = d;
        v.rd = r; v.wt = w; v.busy = b; v.chk_rd = c;
        return v;
    endfunction

    // Transaction-timeline model for instance B: a transfer latched at edge s
    // strobes on edges s+1..s+SC, completes at s+1+SC and leaves HOLD at s+2+SC.
    bit          rnd_on = 1'b0;
    int          cyc, m_start, m_owner, m_last, m_chain, pick;
    bit          m_active;
    logic        m_wr;
    logic [63:0] m_addr, m_wdata, e_rdata;
    logic [2:0]  e_done, e_grant;
    logic        e_read, e_write;

    function automatic int rr_pick(int last, logic [2:0] req);
        for (int i = 1; i <= 3; i++) begin
            int j;
            j = (last + i) % 3;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        if (rnd_on) begin
            e_done = 3'b000;
            if (!m_active) begin
                pick = rr_pick(m_last, req_b);
                if (pick >= 0) begin
                    m_owner  = pick;
                    m_addr   = addr_b[64*m_owner +: 64];
                    m_wdata  = wdata_b[64*m_owner +: 64];
                    m_wr     = wr_b[m_owner];
                    m_active = 1'b1;
                    m_start  = cyc;
                end
            end else if (cyc == m_start + 1 + SC_B) begin
                e_done = 3'(1) << m_owner;
                if (!m_wr) e_rdata = periph_b;
            end else if (cyc == m_start + 2 + SC_B) begin
                if (lock_b[m_owner] && req_b[m_owner] && m_chain < ML_B - 1) begin
                    m_chain++;
                    m_addr  = addr_b[64*m_owner +: 64];
                    m_wdata = wdata_b[64*m_owner +: 64];
                    m_wr    = wr_b[m_owner];
                    m_start = cyc;
                end else begin
                    m_chain  = 0;
                    m_last   = m_owner;
                    m_active = 1'b0;
                end
            end
            e_grant = m_active ? 3'(1) << m_owner : 3'b000;
            e_read  = m_active && !m_wr && cyc >= m_start + 1 && cyc <= m_start + SC_B;
            e_write = m_active &&  m_wr && cyc >= m_start + 1 && cyc <= m_start + SC_B;
            cyc++;
        end
    end

    initial begin
        reset = 1'b0;
        req_a = '0; wr_a = '0; lock_a = '0;
        addr_a = {A1_ADDR, A0_ADDR}; wdata_a = {A1_WD, A0_WD}; periph_a = A_PERIPH;
        req_b = '0; wr_b = '0; lock_b = '0; addr_b = '0; wdata_b = '0; periph_b = '0;

        // Reset state
        #12;
        chk("reset grant_a", grant_a, 0);
        chk("reset busy_a", busy_a, 0);
        chk("reset strobes_a", {read_a, write_a}, 0);
        chk("reset done_a", done_a, 0);
        chk("reset rdata_a", rdata_a, 0);
        chk("reset addr_a", abus_a, 0);
        chk("reset grant_b", grant_b, 0);
        chk("reset busy_b", busy_b, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Single read, then contention with writes, then a locked chain
        tbl.push_back(mk(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 1, 1));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            logic [1:0] g;
            g = (k == 0) ? 2'b10 : 2'b01;
            tbl.push_back(mk(2'b11, 2'b11, 2'b00, g,     2'b00, 0, 0, 1, 0));
            tbl.push_back(mk(2'b11, 2'b11, 2'b00, g,     2'b00, 0, 1, 1, 0));
            tbl.push_back(mk(2'b11, 2'b11, 2'b00, g,     g,     0, 0, 1, 0));
            tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        end
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0));
            tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 0, 0, 1, 0));
            if (k < 3) tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 0, 0, 1, 0));
            else       tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0));
        end
        tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 1, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 1, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_a = tbl[i].req; wr_a = tbl[i].wr; lock_a = tbl[i].lock;
            @(posedge clock); #1;
            chk($sformatf("row%0d grant", i), grant_a, tbl[i].grant);
            chk($sformatf("row%0d done", i), done_a, tbl[i].done);
            chk($sformatf("row%0d read", i), read_a, tbl[i].rd);
            chk($sformatf("row%0d write", i), write_a, tbl[i].wt);
            chk($sformatf("row%0d busy", i), busy_a, tbl[i].busy);
            if (tbl[i].busy)
                chk($sformatf("row%0d address", i), abus_a, tbl[i].grant[1] ? A1_ADDR : A0_ADDR);
            if (tbl[i].wt)
                chk($sformatf("row%0d data_bus", i), dbus_a, tbl[i].grant[1] ? A1_WD : A0_WD);
            if (tbl[i].chk_rd)
                chk($sformatf("row%0d rdata", i), rdata_a, A_PERIPH);
            @(negedge clock);
        end

        // Three-cycle write strobe on instance B
        req_b = 3'b001; wr_b = 3'b001;
        addr_b[63:0] = 64'h2000; wdata_b[63:0] = 64'h55; periph_b = 64'hFFFF_0000;
        @(posedge clock); #1;
        chk("slow grant", grant_b, 3'b001);
        chk("slow setup addr", abus_b, 64'h2000);
        chk("slow setup write", write_b, 0);
        @(negedge clock); req_b = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            chk($sformatf("slow write e%0d", k), write_b, 1);
            chk($sformatf("slow addr e%0d", k), abus_b, 64'h2000);
            chk($sformatf("slow data e%0d", k), dbus_b, 64'h55);
            chk($sformatf("slow done e%0d", k), done_b, 0);
        end
        @(posedge clock); #1;
        chk("slow done", done_b, 3'b001);
        chk("slow hold write", write_b, 0);
        chk("slow hold addr", abus_b, 64'h2000);
        @(posedge clock); #1;
        chk("slow idle busy", busy_b, 0);

        // Asynchronous reset in the middle of a write strobe
        @(negedge clock); req_a = 2'b10; wr_a = 2'b10; lock_a = 2'b00;
        @(posedge clock); #1;
        chk("mid grant", grant_a, 2'b10);
        @(negedge clock); req_a = 2'b00;
        @(posedge clock); #1;
        chk("mid write before reset", write_a, 1);
        #3 reset = 1'b0;
        #1;
        chk("mid reset write", write_a, 0);
        chk("mid reset read", read_a, 0);
        chk("mid reset grant", grant_a, 0);
        chk("mid reset busy", busy_a, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            chk($sformatf("mid reset no done %0d", k), done_a, 0);
        end
        @(negedge clock); reset = 1'b1; req_a = 2'b11; wr_a = 2'b00;
        @(posedge clock); #1;
        chk("post reset grant", grant_a, 2'b01);

        // Master 0 withdraws its request right after the grant
        @(negedge clock); req_a = 2'b00;
        @(posedge clock); #1;
        chk("withdraw read", read_a, 1);
        @(posedge clock); #1;
        chk("withdraw done", done_a, 2'b01);
        chk("withdraw rdata", rdata_a, A_PERIPH);
        @(posedge clock); #1;
        chk("withdraw idle grant", grant_a, 0);
        chk("withdraw idle busy", busy_a, 0);

        // Random traffic on instance B against the timeline model
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        cyc = 0; m_active = 1'b0; m_last = 2; m_chain = 0; m_start = 0;
        e_rdata = '0;
        rnd_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            req_b  = 3'($urandom_range(0, 7));
            wr_b   = 3'($urandom_range(0, 7));
            lock_b = 3'($urandom_range(0, 7));
            for (int m = 0; m < 3; m++) begin
                addr_b[64*m +: 64]  = {$urandom, $urandom};
                wdata_b[64*m +: 64] = {$urandom, $urandom};
            end
            periph_b = {$urandom, $urandom};
            @(posedge clock); #1;
            chk($sformatf("rnd%0d grant", c), grant_b, e_grant);
            chk($sformatf("rnd%0d done", c), done_b, e_done);
            chk($sformatf("rnd%0d busy", c), busy_b, m_active);
            chk($sformatf("rnd%0d read", c), read_b, e_read);
            chk($sformatf("rnd%0d write", c), write_b, e_write);
            if (m_active) chk($sformatf("rnd%0d address", c), abus_b, m_addr);
            if (e_write)  chk($sformatf("rnd%0d data_bus", c), dbus_b, m_wdata);
            if (e_done != 0 && !m_wr) chk($sformatf("rnd%0d rdata", c), rdata_b, e_rdata);
            @(negedge clock);
        end
        rnd_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
